// File: rtl/piso_register_reader.sv
// Parallel-in serial-out reader: captures a word from the register q bus and shifts it out one bit per shift_en edge.
// First bit is valid one cycle after load; load_ready is low during SHIFT and DONE, and shift_en=0 holds the stream.
module piso_register_reader #(
   parameter int WIDTH     = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_in,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      cnt_nxt     = cnt;
      load_ready  = 1'b0;
      sout        = 1'b0;
      sout_valid  = 1'b0;
      frame_start = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               shreg_nxt = d_in;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            sout_valid  = 1'b1;
            sout        = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            frame_start = (cnt == '0);
            if (shift_en) begin
               if (cnt == LAST) begin
                  state_nxt = DONE;
               end else begin
                  // Zero-fill from the far end so the next bit always sits at the output end.
                  shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                  cnt_nxt   = cnt + 1'b1;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/piso_register_reader.md
Name: piso_register_reader

Overview:
- Reader side of the 32-bit parallel register: accepts a parallel word from the register's q output and shifts it out serially, one bit per enabled clock.
- Provides a load handshake towards the register side and a framed serial stream towards a downstream serial consumer.
- Single clock domain; sits between the register bank and any serial monitor or link.

Parameters:
- WIDTH, 32, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- d_in  input  WIDTH  parallel word, normally driven by the register's q output.
- load_valid  input  1  d_in holds a word to transmit.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  downstream consumer takes the current bit on this edge.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid data bit.
- frame_start  output  1  sout is the first bit of a word.
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Reset (async, active-high, any state): state=IDLE, shift register=0, bit counter=0.
  - Outputs during and after reset: load_ready=1, sout=0, sout_valid=0, frame_start=0, done=0.
  - Reset mid-frame aborts the frame; there is no resumption.
- Bit counter width is $clog2(WIDTH); the counter never exceeds WIDTH-1.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1, sout_valid=0, sout=0.
  - A load is accepted on an edge where load_valid=1: capture d_in into the shift register, counter=0, next state SHIFT.
  - shift_en is ignored in IDLE.
- SHIFT:
  - load_ready=0 and sout_valid=1.
  - sout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0]; sout is combinational from the register and is glitch-free per cycle.
  - frame_start = sout_valid AND (counter==0).
  - Edge with shift_en=1 and counter<WIDTH-1: shift the register toward the output end, fill with 0, increment counter.
  - Edge with shift_en=1 and counter==WIDTH-1: next state DONE.
  - shift_en=0: hold; sout, counter and frame_start are stable.
  - load_valid is ignored in SHIFT; the word being shifted is never overwritten.
- DONE:
  - done=1, load_ready=0, sout_valid=0.
  - Unconditional return to IDLE on the next edge.
- Latency and throughput:
  - First bit is valid the cycle after load acceptance.
  - With shift_en held at 1: WIDTH SHIFT cycles, then 1 DONE cycle.
  - Next load is accepted in the following IDLE cycle, giving a minimum of WIDTH+2 cycles per word.
- d_in changing after acceptance has no effect on the frame in flight.
- load_valid held high continuously produces back-to-back frames, each separated by one DONE and one IDLE cycle.
- done and frame_start are never high in the same cycle.

Test Plan:
- Reset asserted asynchronously between clock edges -> all outputs reach their reset values immediately, without waiting for an edge; load_ready=1.
- Load 0xA5A5A5A5 with MSB_FIRST=1 and shift_en=1 -> sout sequence 1,0,1,0,0,1,0,1,... over 32 cycles; frame_start high only on bit 1; done pulses for exactly 1 cycle at cycle 33 after acceptance.
- Load 0x80000001 with MSB_FIRST=0 -> sout is 1, then 30 zeros, then 1; sout_valid is high for exactly 32 cycles.
- Load 0xFFFFFFFF, then toggle shift_en 1,0,0,1,... -> sout stays at 1, the counter advances only on shift_en=1 edges, and done arrives after exactly 32 enabled edges.
- Assert load_valid with d_in=0x12345678 mid-frame of 0xFFFFFFFF -> load is ignored, the in-flight frame is unchanged, and 0x12345678 is accepted only after done.
- Assert reset at bit 10 of a frame -> returns to IDLE with sout_valid=0; a following load of 0x0000FFFF transmits cleanly from bit 0.
